// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional `MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle from accept.
module rv_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            stall
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, is_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              early_out;
  logic [XLEN-1:0]   early_result;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   div_diff, div_sel, div_fixed;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, iter_next, mul_full;

  always_comb begin
    accept   = start & ~flush & (state_q != BUSY);
    is_div   = op[2];
    a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    sign_a   = a_signed & a[XLEN-1];
    sign_b   = b_signed & b[XLEN-1];
    mag_a    = sign_a ? -a : a;
    mag_b    = sign_b ? -b : b;
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early_out    = 1'b0;
    early_result = '0;
    if (is_div && b == '0) begin
      early_out    = 1'b1;
      early_result = op[1] ? a : '1;
    end else if (is_div && !op[0] && a == SMIN && b == '1) begin
      early_out    = 1'b1;
      early_result = op[1] ? '0 : a;
    end
  end
`else
  assign early_out    = 1'b0;
  assign early_result = '0;
`endif

  // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_trial >= {1'b0, mcand_q};
    div_diff  = div_trial[XLEN-1:0] - mcand_q;
    div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
    iter_next = op_q[2] ? div_next : mul_next;
    mul_full  = neg_q ? -iter_next : iter_next;
    div_sel   = op_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
    div_fixed = neg_q ? -div_sel : div_sel;
  end

  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      op_d    = op;
      rd_d    = rd_in;
      count_d = CW'(XLEN);
      mcand_d = is_div ? mag_b : mag_a;
      acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      if (!is_div)
        neg_d = sign_a ^ sign_b;
      else if (op[1])
        neg_d = sign_a;
      else
        neg_d = (sign_a ^ sign_b) & (b != '0);
      if (early_out)
        result_d = early_result;
    end else if (state_q == BUSY && !flush) begin
      acc_d   = iter_next;
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        if (op_q[2])
          result_d = div_fixed;
        else if (op_q[1:0] == 2'b00)
          result_d = mul_full[XLEN-1:0];
        else
          result_d = mul_full[2*XLEN-1:XLEN];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: state_d = start ? (early_out ? DONE : BUSY) : IDLE;
        BUSY:       if (count_q == CW'(1)) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    busy   = (state_q == BUSY);
    done   = (state_q == DONE);
    stall  = (state_q == BUSY) | (start & (state_q == IDLE | state_q == DONE) & ~flush);
    result = result_q;
    rd_out = rd_q;
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: directed RV32M vectors, randomized ops against an
// arithmetic reference model, and busy/back-to-back/flush/reset control scenarios.
module tb_rv_muldiv_unit;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic [RD_W-1:0] rd_in;
  logic            busy, done, stall;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] last_result;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
  } vec_t;

  rv_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      3'd0: begin up = ux * uy; return up[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        up = ux / uy; return up[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        up = ux % uy; return up[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    bit early_en;
    bit special;
`ifdef MULDIV_EARLY_OUT_EN
    early_en = 1'b1;
`else
    early_en = 1'b0;
`endif
    special = (f[2] && y == 0) || ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    return (early_en && special) ? 1 : XLEN + 1;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [RD_W-1:0] tag, output int cycles, output logic [31:0] res,
                        output logic [RD_W-1:0] tag_out, output int stall_err);
    stall_err = 0;
    res       = '0;
    tag_out   = '0;
    @(negedge clk);
    op = f; a = x; b = y; rd_in = tag; start = 1'b1;
    #1;
    if (stall !== 1'b1) stall_err++;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; rd_in = RD_W'($urandom);
    #1;
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      if (stall !== 1'b1) stall_err++;
      @(negedge clk);
      #1;
      cycles++;
    end
    if (done === 1'b1) begin
      res     = result;
      tag_out = rd_out;
      if (stall !== 1'b0) stall_err++;
    end else begin
      cycles = -1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (result !== '0)   begin n_fail++; $display("[TB] FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (rd_out !== '0)   begin n_fail++; $display("[TB] FAIL reset_rd_out: got %h want 0", rd_out); end
    n_cmp++; if (stall !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    last_result = '0;
  endtask

  task automatic test_directed;
    vec_t v[$];
    int cyc, serr;
    logic [31:0] res;
    logic [RD_W-1:0] tag_out, tag;
    v.push_back('{3'd0, 32'd7,          32'd6,          32'h0000_002A});
    v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    v.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF});
    v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD});
    v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF});
    v.push_back('{3'd5, 32'd100,        32'd7,          32'd14});
    v.push_back('{3'd7, 32'd100,        32'd7,          32'd2});
    v.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF});
    v.push_back('{3'd6, 32'd5,          32'd0,          32'd5});
    v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    foreach (v[i]) begin
      tag = RD_W'(i + 1);
      run_op(v[i].f, v[i].x, v[i].y, tag, cyc, res, tag_out, serr);
      n_cmp++; if (res !== v[i].e) begin n_fail++;
        $display("[TB] FAIL dir%0d_result op=%0d: got %h want %h", i, v[i].f, res, v[i].e); end
      n_cmp++; if (cyc != exp_latency(v[i].f, v[i].x, v[i].y)) begin n_fail++;
        $display("[TB] FAIL dir%0d_latency: got %0d want %0d", i, cyc, exp_latency(v[i].f, v[i].x, v[i].y)); end
      n_cmp++; if (tag_out !== tag) begin n_fail++;
        $display("[TB] FAIL dir%0d_rd_out: got %0d want %0d", i, tag_out, tag); end
      n_cmp++; if (serr != 0) begin n_fail++;
        $display("[TB] FAIL dir%0d_stall: %0d bad stall cycles, want 0", i, serr); end
      last_result = v[i].e;
    end
  endtask

  task automatic test_random;
    int cyc, serr, mode;
    logic [2:0] f;
    logic [31:0] x, y, e, res;
    logic [RD_W-1:0] tag, tag_out;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) y = 32'd0;
      else if (mode == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (mode == 2) begin x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(1, 15)); end
      else if (mode == 3) y = -32'($urandom_range(1, 9));
      tag = RD_W'($urandom);
      e = ref_model(f, x, y);
      run_op(f, x, y, tag, cyc, res, tag_out, serr);
      n_cmp++; if (res !== e) begin n_fail++;
        $display("[TB] FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, f, x, y, res, e); end
      n_cmp++; if (cyc != exp_latency(f, x, y)) begin n_fail++;
        $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", i, cyc, exp_latency(f, x, y)); end
      n_cmp++; if (tag_out !== tag || serr != 0) begin n_fail++;
        $display("[TB] FAIL rnd%0d_rd_stall: rd got %0d want %0d, bad stall cycles %0d", i, tag_out, tag, serr); end
      last_result = e;
    end
  endtask

  task automatic test_start_during_busy;
    int cyc, extra;
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd5; rd_in = 5'd3; start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5);
      if (cyc == 5) begin op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd9; end
      #1;
      if (done === 1'b1) break;
    end
    n_cmp++; if (cyc != 33) begin n_fail++; $display("[TB] FAIL busy_start_latency: got %0d want 33", cyc); end
    n_cmp++; if (result !== 32'd15) begin n_fail++; $display("[TB] FAIL busy_start_result: got %h want %h", result, 32'd15); end
    n_cmp++; if (rd_out !== 5'd3) begin n_fail++; $display("[TB] FAIL busy_start_rd_out: got %0d want 3", rd_out); end
    start = 1'b0;
    extra = 0;
    repeat (40) begin @(negedge clk); #1; if (done === 1'b1 || busy === 1'b1) extra++; end
    n_cmp++; if (extra != 0) begin n_fail++; $display("[TB] FAIL busy_start_extra_op: %0d active cycles, want 0", extra); end
    last_result = 32'd15;
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    op = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; rd_in = 5'd4; start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      #1;
      if (done === 1'b1) break;
    end
    n_cmp++; if (cyc != 33) begin n_fail++; $display("[TB] FAIL b2b_first_latency: got %0d want 33", cyc); end
    n_cmp++; if (result !== 32'hFFFF_FFFD) begin n_fail++; $display("[TB] FAIL b2b_first_result: got %h want fffffffd", result); end
    op = 3'd7; a = 32'd100; b = 32'd7; rd_in = 5'd11; start = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_stall_in_done: got %b want 1", stall); end
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      #1;
      if (done === 1'b1) break;
    end
    n_cmp++; if (cyc != 33) begin n_fail++; $display("[TB] FAIL b2b_second_latency: got %0d want 33", cyc); end
    n_cmp++; if (result !== 32'd2) begin n_fail++; $display("[TB] FAIL b2b_second_result: got %h want 2", result); end
    n_cmp++; if (rd_out !== 5'd11) begin n_fail++; $display("[TB] FAIL b2b_second_rd_out: got %0d want 11", rd_out); end
    last_result = 32'd2;
  endtask

  task automatic test_flush;
    int active;
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd3; rd_in = 5'd6; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1; start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9; rd_in = 5'd7;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_done: got %b want 0", done); end
    active = 0;
    repeat (40) begin @(negedge clk); #1; if (done === 1'b1 || busy === 1'b1) active++; end
    n_cmp++; if (active != 0) begin n_fail++; $display("[TB] FAIL flush_late_activity: %0d active cycles, want 0", active); end
    n_cmp++; if (result !== last_result) begin n_fail++; $display("[TB] FAIL flush_result_held: got %h want %h", result, last_result); end
  endtask

  task automatic test_reset_mid;
    int active;
    @(negedge clk);
    op = 3'd3; a = $urandom; b = $urandom; rd_in = 5'd13; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin n_fail++;
      $display("[TB] FAIL rst_mid_ctrl: busy=%b done=%b stall=%b want all 0", busy, done, stall); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_result: got %h want 0", result); end
    n_cmp++; if (rd_out !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_rd_out: got %0d want 0", rd_out); end
    active = 0;
    repeat (40) begin @(negedge clk); #1; if (done === 1'b1) active++; end
    n_cmp++; if (active != 0) begin n_fail++; $display("[TB] FAIL rst_mid_done: %0d done pulses, want 0", active); end
    last_result = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
